// File: rtl/class_hvec_sweep_ctrl.sv
// Sweeps every (class, frame) address of the class hypervector ROM and streams the words out over valid/ready.
// Optional feature: define CLASS_SKIP_MASK_EN to add class_mask, which skips disabled classes.
module class_hvec_sweep_ctrl #(
    parameter int DI_PARALLEL_W_BITS = 64,
    parameter int N_CLASSES          = 8,
    parameter int N_FRAMES           = 3,
    parameter int CLASS_ID_W         = 3,
    parameter int FRAME_IDX_W        = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
`ifdef CLASS_SKIP_MASK_EN
    input  logic [N_CLASSES-1:0]          class_mask,
`endif
    output logic [CLASS_ID_W-1:0]         frame_id,
    output logic [FRAME_IDX_W-1:0]        frame_index,
    input  logic [DI_PARALLEL_W_BITS-1:0] class_vec_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [DI_PARALLEL_W_BITS-1:0] out_data,
    output logic [CLASS_ID_W-1:0]         out_class,
    output logic [FRAME_IDX_W-1:0]        out_frame,
    output logic                          out_last_frame,
    output logic                          out_last_class,
    output logic                          busy,
    output logic                          done
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    localparam logic [FRAME_IDX_W-1:0] LAST_FRAME = FRAME_IDX_W'(N_FRAMES - 1);

    state_t state, state_nxt;

    logic [N_CLASSES-1:0]  start_mask;
    logic [N_CLASSES-1:0]  act_mask;
    logic [CLASS_ID_W-1:0] first_cls;
    logic [CLASS_ID_W-1:0] last_cls;
    logic [CLASS_ID_W-1:0] next_cls;
    logic                  go;
    logic                  cap;
    logic                  accept;
    logic                  last_addr;

`ifdef CLASS_SKIP_MASK_EN
    logic [N_CLASSES-1:0] mask_q;
    assign start_mask = class_mask;
    assign act_mask   = mask_q;
`else
    assign start_mask = '1;
    assign act_mask   = '1;
`endif

    assign go        = (state == S_IDLE) && start && !abort;
    assign cap       = (state == S_RUN) && (!out_valid || out_ready);
    assign accept    = out_valid && out_ready;
    assign last_addr = (frame_index == LAST_FRAME) && (frame_id == last_cls);
    assign busy      = (state != S_IDLE);
    assign done      = (state == S_DONE);

    // First enabled class of a new sweep, highest enabled class, and the next enabled class above frame_id.
    always_comb begin
        first_cls = '0;
        last_cls  = '0;
        next_cls  = frame_id;
        for (int i = N_CLASSES - 1; i >= 0; i--) begin
            if (start_mask[i]) first_cls = CLASS_ID_W'(i);
            if (act_mask[i] && (CLASS_ID_W'(i) > frame_id)) next_cls = CLASS_ID_W'(i);
        end
        for (int i = 0; i < N_CLASSES; i++) begin
            if (act_mask[i]) last_cls = CLASS_ID_W'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (go) state_nxt = (start_mask == '0) ? S_DONE : S_RUN;
            S_RUN: begin
                if (abort)                 state_nxt = S_IDLE;
                else if (cap && last_addr) state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (abort)       state_nxt = S_IDLE;
                else if (accept) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Address counters and the output register; a capture refills the slot in the same cycle it is accepted.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_id       <= '0;
            frame_index    <= '0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_class      <= '0;
            out_frame      <= '0;
            out_last_frame <= 1'b0;
            out_last_class <= 1'b0;
`ifdef CLASS_SKIP_MASK_EN
            mask_q         <= '0;
`endif
        end else if (abort && (state != S_IDLE)) begin
            out_valid   <= 1'b0;
            frame_id    <= '0;
            frame_index <= '0;
        end else begin
            if (go) begin
                frame_id    <= first_cls;
                frame_index <= '0;
`ifdef CLASS_SKIP_MASK_EN
                mask_q      <= class_mask;
`endif
            end
            if (cap) begin
                out_data       <= class_vec_in;
                out_class      <= frame_id;
                out_frame      <= frame_index;
                out_last_frame <= (frame_index == LAST_FRAME);
                out_last_class <= (frame_id == last_cls);
                out_valid      <= 1'b1;
                if (frame_index == LAST_FRAME) begin
                    frame_index <= '0;
                    frame_id    <= last_addr ? '0 : next_cls;
                end else begin
                    frame_index <= frame_index + 1'b1;
                end
            end else if (accept) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
